bus_master: RTL and testbench

//  Initiator side of the shared 20-bit-address / 16-bit-data system bus. Accepts one

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_master.sv | 196 +++++++++++++++++++
 tb/tb_bus_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the system-bus initiator (bus_master):
//   - default address/data widths of the shared bus
//   - FSM state encoding (IDLE / ACCESS / RESP)
//   - maximum supported wait states and the matching counter width
// No ports; imported by bus_master with `import bus_pkg::*`.
// The optional transaction counters are selected in bus_master by the
// macro BUS_MASTER_TXN_COUNT_EN.
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  // Slow targets may stretch an access by up to this many extra cycles.
  localparam int MAX_WAIT   = 15;
  localparam int CNT_W      = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage : bus_pkg

// File: rtl/bus_master.sv
// -----------------------------------------------------------------------------
// bus_master
// Initiator side of the shared address/data system bus. Takes one word
// read/write request at a time from the CPU (valid/ready), runs a bus access
// of WAIT_STATES+1 cycles, then presents the response (valid/ready).
// Every output is registered: there is no combinational path from req_* to
// the bus pins.
//
// Parameters
//   ADDR_W       bus address width (default 20)
//   DATA_W       bus data width (default 16)
//   WAIT_STATES  extra ACCESS cycles beyond the first, 0..15
//
// Ports
//   clk          in     system clock, all state on posedge
//   rst_n        in     asynchronous active-low reset
//   req_valid    in     CPU request present
//   req_ready    out    master can accept (IDLE only, low until first clk)
//   req_write    in     1=write, 0=read
//   req_addr     in     word address
//   req_wdata    in     write data
//   resp_valid   out    transaction complete
//   resp_ready   in     CPU consumes response
//   resp_rdata   out    captured read data (0 after a write)
//   bus_addr     out    bus address (holds last value after an access)
//   bus_data     inout  driven with write data only during a write ACCESS
//   read         out    bus read strobe
//   write        out    bus write strobe
//   rd_count     out    completed reads  (only with BUS_MASTER_TXN_COUNT_EN)
//   wr_count     out    completed writes (only with BUS_MASTER_TXN_COUNT_EN)
//
// Configuration
//   BUS_MASTER_TXN_COUNT_EN  when defined, adds the 32-bit wrapping
//                            rd_count/wr_count outputs.
// -----------------------------------------------------------------------------
module bus_master
  import bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
`ifdef BUS_MASTER_TXN_COUNT_EN
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
`endif
  output logic [ADDR_W-1:0] bus_addr,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic              read,
  output logic              write
);

  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : g_bad_wait
    $error("bus_master: WAIT_STATES=%0d outside 0..%0d", WAIT_STATES, MAX_WAIT);
  end

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              rvld_q, rvld_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef BUS_MASTER_TXN_COUNT_EN
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    rvld_d  = rvld_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
`ifdef BUS_MASTER_TXN_COUNT_EN
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // rdy_q is low for the first cycle after reset, so a request is only
        // taken once req_ready has actually been shown to the CPU.
        if (rdy_q && req_valid) begin
          state_d = ST_ACCESS;
          rdy_d   = 1'b0;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = ~req_write;
          wr_d    = req_write;
          cnt_d   = WAIT_INIT;
        end else begin
          rdy_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          // Final access edge: target latches write data, we sample read data.
          state_d = ST_RESP;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          rvld_d  = 1'b1;
          rdata_d = wr_q ? '0 : bus_data;
`ifdef BUS_MASTER_TXN_COUNT_EN
          if (rd_q) rd_cnt_d = rd_cnt_q + 32'd1;
          if (wr_q) wr_cnt_d = wr_cnt_q + 32'd1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rvld_d  = 1'b0;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        rvld_d  = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef BUS_MASTER_TXN_COUNT_EN
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
`ifdef BUS_MASTER_TXN_COUNT_EN
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
`endif
    end
  end

  // Write data is only observable while wr_q enables the driver, so it needs
  // no reset.
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  // wr_q doubles as the bus driver enable: the pins are driven exactly while
  // the write strobe is up, and a reset releases both together.
  assign bus_data   = wr_q ? wdata_q : {DATA_W{1'bz}};
  assign bus_addr   = addr_q;
  assign read       = rd_q;
  assign write      = wr_q;
  assign req_ready  = rdy_q;
  assign resp_valid = rvld_q;
  assign resp_rdata = rdata_q;
`ifdef BUS_MASTER_TXN_COUNT_EN
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;
`endif

endmodule : bus_master

// File: tb/tb_bus_master.sv
// -----------------------------------------------------------------------------
// tb_bus_master
// Bench for bus_master. dut0 (WAIT_STATES=0) sits on a 16-word memory target
// at 0x00100..0x0010F; dut3 (WAIT_STATES=3) sits on a read-only target that
// returns {8'hC3, addr[7:0]}.
// -----------------------------------------------------------------------------
module tb_bus_master;

  localparam int AW = 20;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- dut0 : zero wait states ----------------
  logic          req_valid, req_write, resp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, resp_valid;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] bus_addr;
  wire  [DW-1:0] bus_data;
  logic          bus_rd, bus_wr;

  // ---------------- dut3 : three wait states ----------------
  logic          req_valid3, req_write3, resp_ready3;
  logic [AW-1:0] req_addr3;
  logic [DW-1:0] req_wdata3;
  logic          req_ready3, resp_valid3;
  logic [DW-1:0] resp_rdata3;
  logic [AW-1:0] bus_addr3;
  wire  [DW-1:0] bus_data3;
  logic          bus_rd3, bus_wr3;

`ifdef BUS_MASTER_TXN_COUNT_EN
  logic [31:0] rd_count, wr_count, rd_count3, wr_count3;
`endif

  bus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
`ifdef BUS_MASTER_TXN_COUNT_EN
    .rd_count(rd_count), .wr_count(wr_count),
`endif
    .bus_addr(bus_addr), .bus_data(bus_data), .read(bus_rd), .write(bus_wr)
  );

  bus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rdata(resp_rdata3),
`ifdef BUS_MASTER_TXN_COUNT_EN
    .rd_count(rd_count3), .wr_count(wr_count3),
`endif
    .bus_addr(bus_addr3), .bus_data(bus_data3), .read(bus_rd3), .write(bus_wr3)
  );

  // Memory target for dut0: combinational read, write latched on posedge.
  logic [DW-1:0] mem [16];
  logic          in_rng;
  assign in_rng   = (bus_addr[19:4] == 16'h0010);
  assign bus_data = (bus_rd && in_rng) ? mem[bus_addr[3:0]] : {DW{1'bz}};
  always @(posedge clk) begin
    if (bus_wr && in_rng) mem[bus_addr[3:0]] <= bus_data;
  end

  // Read-only target for dut3.
  assign bus_data3 = bus_rd3 ? {8'hC3, bus_addr3[7:0]} : {DW{1'bz}};

  // Transaction-level reference: what memory should hold, and how many
  // reads/writes completed since the last reset.
  logic [DW-1:0] shadow [16];
  bit            shadow_vld [16];
  int            n_rd, n_wr;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One dut0 transaction with the CPU stalling the response for `stall`
  // cycles. Checks strobes, bus data, latency and response stability.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int stall,
                        output logic [DW-1:0] rdata);
    int          strobes, lat, waited;
    bit          got;
    logic [3:0]  idx;
    idx = addr[3:0];
    rdata = '0;
    req_write = wr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    if (!req_ready) begin
      chk("accept timeout req_ready", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;            // accept edge N
    req_valid = 1'b0;
    strobes = 0; lat = 0; got = 0;
    while (!got && lat < 40) begin
      if (resp_valid) got = 1;
      else begin
        if (bus_rd || bus_wr) begin
          strobes++;
          chk("strobe direction", {30'b0, bus_wr, bus_rd}, wr ? 32'd2 : 32'd1);
          chk("bus_addr", bus_addr, addr);
          if (wr) chk("bus_data write", bus_data, wdata);
          else    chk("bus_data read (master quiet)", bus_data, shadow[idx]);
        end
        @(posedge clk); #1; lat++;
      end
    end
    chk("resp latency", lat, 32'd1);
    chk("strobe cycles", strobes, 32'd1);
    chk("strobes low in RESP", {30'b0, bus_wr, bus_rd}, 32'd0);
    if (wr) chk("bus released after write", {31'b0, bus_data !== wdata}, 32'd1);
    rdata = resp_rdata;
    for (int s = 0; s < stall; s++) begin
      resp_ready = 1'b0;
      req_valid = 1'b1; req_write = ~wr; req_addr = ~addr;
      @(posedge clk); #1;
      chk("stall resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall resp_rdata", resp_rdata, rdata);
      chk("stall req_ready", {31'b0, req_ready}, 32'd0);
      chk("stall no strobe", {30'b0, bus_wr, bus_rd}, 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("resp_valid drop", {31'b0, resp_valid}, 32'd0);
    chk("req_ready after RESP", {31'b0, req_ready}, 32'd1);
    if (wr) begin
      shadow[idx] = wdata; shadow_vld[idx] = 1; n_wr++;
    end else n_rd++;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs [7];

  initial begin
    logic [DW-1:0] rd;
    logic [DW-1:0] old9;
    int            strobes, lat, waited;
    bit            got;

    vecs[0] = '{1'b1, 20'h00105, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 20'h00105, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 20'h0010F, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 20'h0010F, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 20'h00100, 16'h8001, 16'h0000};
    vecs[5] = '{1'b0, 20'h00100, 16'h0000, 16'h8001};
    vecs[6] = '{1'b0, 20'h00105, 16'h0000, 16'hBEEF};

    for (int i = 0; i < 16; i++) begin shadow[i] = '0; shadow_vld[i] = 0; end
    n_rd = 0; n_wr = 0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; resp_ready = 1;
    req_valid3 = 0; req_write3 = 0; req_addr3 = '0; req_wdata3 = '0; resp_ready3 = 1;

    // ---- reset values ----
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst strobes", {30'b0, bus_wr, bus_rd}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("req_ready held in reset", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready after first clk", {31'b0, req_ready}, 32'd1);

    // ---- directed table ----
    foreach (vecs[i]) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, rd);
      chk($sformatf("vec%0d resp_rdata", i), rd, vecs[i].exp);
    end
    chk("mem[5] after write", mem[5], 32'hBEEF);

    // ---- response back-pressure: 5 stalled cycles with a competing request ----
    do_txn(1'b0, 20'h0010F, 16'h0000, 5, rd);
    chk("stalled read rdata", rd, 32'h1234);
    do_txn(1'b1, 20'h00102, 16'h0F0F, 0, rd);
    chk("after stall write rdata", rd, 32'h0);

    // ---- reset pulse in the middle of a write access ----
    old9 = mem[9];
    req_write = 1; req_addr = 20'h00109; req_wdata = 16'h7777; req_valid = 1;
    waited = 0;
    while (!req_ready && waited < 20) begin @(posedge clk); #1; waited++; end
    @(posedge clk); #1;
    req_valid = 0;
    chk("mid-reset write up", {31'b0, bus_wr}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-reset write released", {31'b0, bus_wr}, 32'd0);
    chk("mid-reset read low", {31'b0, bus_rd}, 32'd0);
    chk("mid-reset bus released", {31'b0, bus_data !== 16'h7777}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_rd = 0; n_wr = 0;
    got = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (resp_valid) got = 1;
    end
    chk("no response after reset", {31'b0, got}, 32'd0);
    chk("abandoned write not stored", mem[9], old9);
    do_txn(1'b1, 20'h00109, 16'h5A5A, 0, rd);
    chk("post-reset write rdata", rd, 32'h0);
    do_txn(1'b0, 20'h00109, 16'h0000, 0, rd);
    chk("post-reset read rdata", rd, 32'h5A5A);

    // ---- randomized traffic against the shadow memory ----
    for (int t = 0; t < 40; t++) begin
      logic [3:0]    idx;
      logic          wr;
      logic [DW-1:0] wd;
      logic [DW-1:0] exp;
      idx = 4'($urandom_range(0, 15));
      wr  = !shadow_vld[idx] || ($urandom_range(0, 1) == 1);
      wd  = 16'($urandom());
      if (wd == 16'h0) wd = 16'h0001;
      exp = wr ? 16'h0 : shadow[idx];
      do_txn(wr, {16'h0010, idx}, wd, int'($urandom_range(0, 2)), rd);
      chk($sformatf("rand%0d resp_rdata", t), rd, exp);
    end

    // ---- dut3: three wait states, read 0x00100 ----
    req_addr3 = 20'h00100; req_write3 = 0; req_valid3 = 1;
    waited = 0;
    while (!req_ready3 && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("w3 req_ready", {31'b0, req_ready3}, 32'd1);
    @(posedge clk); #1;
    req_valid3 = 0;
    strobes = 0; lat = 0; got = 0;
    while (!got && lat < 40) begin
      if (resp_valid3) got = 1;
      else begin
        if (bus_rd3) begin
          strobes++;
          chk("w3 bus_data read", bus_data3, 32'hC300);
        end
        chk("w3 no write strobe", {31'b0, bus_wr3}, 32'd0);
        @(posedge clk); #1; lat++;
      end
    end
    chk("w3 read strobe cycles", strobes, 32'd4);
    chk("w3 resp latency", lat, 32'd4);
    chk("w3 resp_rdata", resp_rdata3, 32'hC300);
    @(posedge clk); #1;
    chk("w3 req_ready after RESP", {31'b0, req_ready3}, 32'd1);

`ifdef BUS_MASTER_TXN_COUNT_EN
    chk("wr_count", wr_count, n_wr);
    chk("rd_count", rd_count, n_rd);
    chk("w3 rd_count", rd_count3, 32'd1);
    chk("w3 wr_count", wr_count3, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_bus_master
